// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Brief    : Button debounce and field-by-field time/alarm edit controller.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TIMEOUT_CYCLES  = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_alarm,
  input  logic       btn_inc,
  input  logic [7:0] hh_cur,
  input  logic [7:0] mm_cur,
  input  logic [7:0] ss_cur,
  input  logic       pm_cur,
  output logic [7:0] hh_load,
  output logic [7:0] mm_load,
  output logic [7:0] ss_load,
  output logic       pm_load,
  output logic       load_time,
  output logic       load_alarm,
  output logic       editing,
  output logic [1:0] edit_field
);

  localparam int c_DB_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int c_TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int c_NBTN  = 3;

  localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop sync, debounce counter, rising-edge press pulse
  // ---------------------------------------------------------------------------
  logic [c_NBTN-1:0] w_btn_raw;
  logic [c_NBTN-1:0] w_press;
  logic              w_press_mode;
  logic              w_press_alarm;
  logic              w_press_inc;

  assign w_btn_raw = {btn_inc, btn_alarm, btn_mode};

  generate
    for (genvar gi = 0; gi < c_NBTN; gi++) begin : g_btn
      logic              r_sync1_q;
      logic              r_sync2_q;
      logic              r_level_q;
      logic              r_level_dly_q;
      logic              r_press_q;
      logic [c_DB_W-1:0] r_cnt_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync1_q     <= 1'b0;
          r_sync2_q     <= 1'b0;
          r_level_q     <= 1'b0;
          r_level_dly_q <= 1'b0;
          r_press_q     <= 1'b0;
          r_cnt_q       <= '0;
        end else begin
          r_sync1_q     <= w_btn_raw[gi];
          r_sync2_q     <= r_sync1_q;
          r_level_dly_q <= r_level_q;
          r_press_q     <= r_level_q & ~r_level_dly_q;
          // Any cycle agreeing with the accepted level restarts the count.
          if (r_sync2_q == r_level_q) begin
            r_cnt_q <= '0;
          end else if (r_cnt_q == c_DB_LAST) begin
            r_level_q <= r_sync2_q;
            r_cnt_q   <= '0;
          end else begin
            r_cnt_q <= r_cnt_q + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_press_q;
    end
  endgenerate

  assign w_press_mode  = w_press[0];
  assign w_press_alarm = w_press[1];
  assign w_press_inc   = w_press[2];

  // ---------------------------------------------------------------------------
  // BCD helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] f_san_hh(input logic [7:0] v);
    logic ok;
    ok = ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
         ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    return ok ? v : 8'h12;
  endfunction

  function automatic logic [7:0] f_san_ms(input logic [7:0] v);
    return ((v[7:4] <= 4'd5) && (v[3:0] <= 4'd9)) ? v : 8'h00;
  endfunction

  function automatic logic [7:0] f_inc_hh(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h12)           r = 8'h01;
    else if (v[3:0] == 4'd9)  r = 8'h10;
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] f_inc_ms(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)           r = 8'h00;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Edit state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EDIT_HH = 3'd1,
    S_EDIT_MM = 3'd2,
    S_EDIT_SS = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  state_t              r_state_q, w_state_d;
  logic                r_target_q, w_target_d;
  logic [7:0]          r_hh_q, w_hh_d;
  logic [7:0]          r_mm_q, w_mm_d;
  logic [7:0]          r_ss_q, w_ss_d;
  logic                r_pm_q, w_pm_d;
  logic [7:0]          r_al_hh_q, w_al_hh_d;
  logic [7:0]          r_al_mm_q, w_al_mm_d;
  logic [7:0]          r_al_ss_q, w_al_ss_d;
  logic                r_al_pm_q, w_al_pm_d;
  logic [c_TMO_W-1:0]  r_tmo_q, w_tmo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q  <= S_IDLE;
      r_target_q <= 1'b0;
      r_hh_q     <= 8'h12;
      r_mm_q     <= 8'h00;
      r_ss_q     <= 8'h00;
      r_pm_q     <= 1'b0;
      r_al_hh_q  <= 8'h12;
      r_al_mm_q  <= 8'h00;
      r_al_ss_q  <= 8'h00;
      r_al_pm_q  <= 1'b0;
      r_tmo_q    <= '0;
    end else begin
      r_state_q  <= w_state_d;
      r_target_q <= w_target_d;
      r_hh_q     <= w_hh_d;
      r_mm_q     <= w_mm_d;
      r_ss_q     <= w_ss_d;
      r_pm_q     <= w_pm_d;
      r_al_hh_q  <= w_al_hh_d;
      r_al_mm_q  <= w_al_mm_d;
      r_al_ss_q  <= w_al_ss_d;
      r_al_pm_q  <= w_al_pm_d;
      r_tmo_q    <= w_tmo_d;
    end
  end

  always_comb begin
    w_state_d  = r_state_q;
    w_target_d = r_target_q;
    w_hh_d     = r_hh_q;
    w_mm_d     = r_mm_q;
    w_ss_d     = r_ss_q;
    w_pm_d     = r_pm_q;
    w_al_hh_d  = r_al_hh_q;
    w_al_mm_d  = r_al_mm_q;
    w_al_ss_d  = r_al_ss_q;
    w_al_pm_d  = r_al_pm_q;
    w_tmo_d    = r_tmo_q;

    unique case (r_state_q)
      S_IDLE: begin
        w_tmo_d = '0;
        if (w_press_mode) begin
          w_hh_d     = f_san_hh(hh_cur);
          w_mm_d     = f_san_ms(mm_cur);
          w_ss_d     = f_san_ms(ss_cur);
          w_pm_d     = pm_cur;
          w_target_d = 1'b0;
          w_state_d  = S_EDIT_HH;
        end else if (w_press_alarm) begin
          w_hh_d     = f_san_hh(r_al_hh_q);
          w_mm_d     = f_san_ms(r_al_mm_q);
          w_ss_d     = f_san_ms(r_al_ss_q);
          w_pm_d     = r_al_pm_q;
          w_target_d = 1'b1;
          w_state_d  = S_EDIT_HH;
        end
      end

      S_EDIT_HH, S_EDIT_MM, S_EDIT_SS: begin
        // mode takes precedence; a coincident inc is dropped.
        if (w_press_mode) begin
          w_tmo_d = '0;
          unique case (r_state_q)
            S_EDIT_HH: w_state_d = S_EDIT_MM;
            S_EDIT_MM: w_state_d = S_EDIT_SS;
            default:   w_state_d = S_COMMIT;
          endcase
        end else if (w_press_inc) begin
          w_tmo_d = '0;
          unique case (r_state_q)
            S_EDIT_HH: begin
              w_hh_d = f_inc_hh(r_hh_q);
              if (r_hh_q == 8'h11) w_pm_d = ~r_pm_q;
            end
            S_EDIT_MM: w_mm_d = f_inc_ms(r_mm_q);
            default:   w_ss_d = f_inc_ms(r_ss_q);
          endcase
        end else if (r_tmo_q == c_TMO_LAST) begin
          w_tmo_d   = '0;
          w_state_d = S_IDLE;
        end else begin
          w_tmo_d = r_tmo_q + 1'b1;
        end
      end

      S_COMMIT: begin
        if (r_target_q) begin
          w_al_hh_d = r_hh_q;
          w_al_mm_d = r_mm_q;
          w_al_ss_d = r_ss_q;
          w_al_pm_d = r_pm_q;
        end
        w_state_d = S_IDLE;
      end

      default: w_state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hh_load    = r_hh_q;
  assign mm_load    = r_mm_q;
  assign ss_load    = r_ss_q;
  assign pm_load    = r_pm_q;
  assign load_time  = (r_state_q == S_COMMIT) & ~r_target_q;
  assign load_alarm = (r_state_q == S_COMMIT) &  r_target_q;
  assign editing    = (r_state_q == S_EDIT_HH) || (r_state_q == S_EDIT_MM) ||
                      (r_state_q == S_EDIT_SS);

  always_comb begin
    edit_field = 2'd0;
    unique case (r_state_q)
      S_EDIT_HH: edit_field = 2'd1;
      S_EDIT_MM: edit_field = 2'd2;
      S_EDIT_SS: edit_field = 2'd3;
      default:   edit_field = 2'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Brief    : Table-driven self-checking bench for clock_set_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

  localparam int DB = 4;
  localparam int TO = 50;
  localparam int NV = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_alarm, btn_inc;
  logic [7:0] hh_cur, mm_cur, ss_cur;
  logic       pm_cur;
  logic [7:0] hh_load, mm_load, ss_load;
  logic       pm_load, load_time, load_alarm, editing;
  logic [1:0] edit_field;

  always #5 clk = ~clk;

  clock_set_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_alarm(btn_alarm), .btn_inc(btn_inc),
    .hh_cur(hh_cur), .mm_cur(mm_cur), .ss_cur(ss_cur), .pm_cur(pm_cur),
    .hh_load(hh_load), .mm_load(mm_load), .ss_load(ss_load), .pm_load(pm_load),
    .load_time(load_time), .load_alarm(load_alarm),
    .editing(editing), .edit_field(edit_field)
  );

  // btn = {mode, alarm, inc}
  typedef struct {
    logic [2:0] btn;
    logic [7:0] hh_c, mm_c, ss_c;
    logic       pm_c;
    logic [7:0] hh, mm, ss;
    logic       pm;
    logic [1:0] fld;
  } vec_t;

  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;
  int lt_cnt = 0, la_cnt = 0, ovl_cnt = 0;
  logic [7:0] la_hh;
  logic       la_pm;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (load_time) lt_cnt++;
    if (load_alarm) begin
      la_cnt++;
      la_hh = hh_load;
      la_pm = pm_load;
    end
    if (load_time && load_alarm) ovl_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] b);
    @(negedge clk);
    btn_mode  = b[2];
    btn_alarm = b[1];
    btn_inc   = b[0];
    repeat (DB + 4) @(negedge clk);
    btn_mode  = 1'b0;
    btn_alarm = 1'b0;
    btn_inc   = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic apply_vec(input int i);
    hh_cur = vecs[i].hh_c;
    mm_cur = vecs[i].mm_c;
    ss_cur = vecs[i].ss_c;
    pm_cur = vecs[i].pm_c;
    press(vecs[i].btn);
    check($sformatf("v%0d_hh", i), hh_load, vecs[i].hh);
    check($sformatf("v%0d_mm", i), mm_load, vecs[i].mm);
    check($sformatf("v%0d_ss", i), ss_load, vecs[i].ss);
    check($sformatf("v%0d_pm", i), pm_load, vecs[i].pm);
    check($sformatf("v%0d_field", i), edit_field, vecs[i].fld);
    check($sformatf("v%0d_editing", i), editing, (vecs[i].fld != 2'd0));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_vec(i);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hh"}, hh_load, 8'h12);
    check({tag, "_mm"}, mm_load, 8'h00);
    check({tag, "_ss"}, ss_load, 8'h00);
    check({tag, "_pm"}, pm_load, 1'b0);
    check({tag, "_lt"}, load_time, 1'b0);
    check({tag, "_la"}, load_alarm, 1'b0);
    check({tag, "_editing"}, editing, 1'b0);
    check({tag, "_field"}, edit_field, 2'd0);
  endtask

  int lt0, la0;
  bit done;

  initial begin
    // Time edit with hh/mm wrap
    vecs[0]  = '{3'b100, 8'h11, 8'h59, 8'h34, 1'b0, 8'h11, 8'h59, 8'h34, 1'b0, 2'd1};
    vecs[1]  = '{3'b001, 8'h11, 8'h59, 8'h34, 1'b0, 8'h12, 8'h59, 8'h34, 1'b1, 2'd1};
    vecs[2]  = '{3'b001, 8'h11, 8'h59, 8'h34, 1'b0, 8'h01, 8'h59, 8'h34, 1'b1, 2'd1};
    vecs[3]  = '{3'b100, 8'h11, 8'h59, 8'h34, 1'b0, 8'h01, 8'h59, 8'h34, 1'b1, 2'd2};
    vecs[4]  = '{3'b001, 8'h11, 8'h59, 8'h34, 1'b0, 8'h01, 8'h00, 8'h34, 1'b1, 2'd2};
    vecs[5]  = '{3'b100, 8'h11, 8'h59, 8'h34, 1'b0, 8'h01, 8'h00, 8'h34, 1'b1, 2'd3};
    // Alarm edit from reset shadow 12:00:00 AM, hh up to 07
    vecs[6]  = '{3'b010, 8'h11, 8'h59, 8'h34, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 2'd1};
    for (int k = 1; k <= 7; k++)
      vecs[6+k] = '{3'b001, 8'h11, 8'h59, 8'h34, 1'b0, 8'(k), 8'h00, 8'h00, 1'b0, 2'd1};
    vecs[14] = '{3'b100, 8'h11, 8'h59, 8'h34, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 2'd2};
    vecs[15] = '{3'b100, 8'h11, 8'h59, 8'h34, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 2'd3};
    // Re-entry seeds from the committed alarm
    vecs[16] = '{3'b010, 8'h11, 8'h59, 8'h34, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 2'd1};
    vecs[17] = '{3'b100, 8'h11, 8'h59, 8'h34, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 2'd2};
    vecs[18] = '{3'b100, 8'h11, 8'h59, 8'h34, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 2'd3};
    // mode+alarm together -> time edit, with sanitized seed
    vecs[19] = '{3'b110, 8'h1A, 8'h75, 8'h00, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 2'd1};
    vecs[20] = '{3'b100, 8'h1A, 8'h75, 8'h00, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 2'd2};
    vecs[21] = '{3'b100, 8'h1A, 8'h75, 8'h00, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 2'd3};
    vecs[22] = '{3'b100, 8'h1A, 8'h75, 8'h00, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 2'd0};
    // Setup for bounce test: EDIT_MM with mm=41
    vecs[23] = '{3'b100, 8'h05, 8'h41, 8'h00, 1'b0, 8'h05, 8'h41, 8'h00, 1'b0, 2'd1};
    vecs[24] = '{3'b100, 8'h05, 8'h41, 8'h00, 1'b0, 8'h05, 8'h41, 8'h00, 1'b0, 2'd2};

    reset = 1'b1;
    btn_mode = 1'b0; btn_alarm = 1'b0; btn_inc = 1'b0;
    hh_cur = 8'h00; mm_cur = 8'h00; ss_cur = 8'h00; pm_cur = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Time edit, then commit with exact strobe latency
    run_vecs(0, 5);
    lt0 = lt_cnt; la0 = la_cnt;
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (DB + 3) @(posedge clk);
    #1 check("tcommit_early", load_time, 1'b0);
    @(posedge clk);
    #1;
    check("tcommit_strobe", load_time, 1'b1);
    check("tcommit_no_alarm", load_alarm, 1'b0);
    check("tcommit_hh", hh_load, 8'h01);
    check("tcommit_mm", mm_load, 8'h00);
    check("tcommit_ss", ss_load, 8'h34);
    check("tcommit_pm", pm_load, 1'b1);
    @(posedge clk);
    #1;
    check("tcommit_width", load_time, 1'b0);
    check("tcommit_hold_hh", hh_load, 8'h01);
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (DB + 4) @(negedge clk);
    check("tcommit_count", lt_cnt - lt0, 1);
    check("tcommit_idle", edit_field, 2'd0);

    // Alarm edit and commit
    run_vecs(6, 15);
    lt0 = lt_cnt; la0 = la_cnt;
    press(3'b100);
    check("acommit_count", la_cnt - la0, 1);
    check("acommit_no_time", lt_cnt - lt0, 0);
    check("acommit_hh", la_hh, 8'h07);
    check("acommit_pm", la_pm, 1'b0);
    check("acommit_idle", editing, 1'b0);

    // Re-enter alarm edit, reach EDIT_SS, then let it time out
    run_vecs(16, 18);
    lt0 = lt_cnt; la0 = la_cnt;
    repeat (25) @(negedge clk);
    check("timeout_not_early", editing, 1'b1);
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!editing) done = 1'b1;
    end
    check("timeout_reached", done, 1'b1);
    check("timeout_field", edit_field, 2'd0);
    check("timeout_no_lt", lt_cnt - lt0, 0);
    check("timeout_no_la", la_cnt - la0, 0);

    // Priority and sanitized seeding; commit must go to time
    lt0 = lt_cnt; la0 = la_cnt;
    run_vecs(19, 22);
    check("prio_time_strobe", lt_cnt - lt0, 1);
    check("prio_no_alarm", la_cnt - la0, 0);

    // Bounce rejection in EDIT_MM
    run_vecs(23, 24);
    for (int k = 0; k < 10; k++) begin
      btn_inc = (k % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_inc = 1'b0;
    repeat (4) @(negedge clk);
    check("bounce_no_change", mm_load, 8'h41);
    btn_inc = 1'b1;
    repeat (10) @(negedge clk);
    btn_inc = 1'b0;
    repeat (DB + 4) @(negedge clk);
    check("bounce_one_inc", mm_load, 8'h42);
    check("bounce_field", edit_field, 2'd2);

    // Reset mid-edit
    lt0 = lt_cnt; la0 = la_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midreset");
    repeat (3) @(negedge clk);
    check("midreset_no_lt", lt_cnt - lt0, 0);
    check("midreset_no_la", la_cnt - la0, 0);
    check("strobe_overlap", ovl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
